// File: rtl/cpu_mem_responder.sv
// -----------------------------------------------------------------------------
// cpu_mem_responder
//
// Memory-side responder for the 16-bit CPU bus. Holds one unified array:
// program words at 0..PROG_END-1, data words at PROG_END..DEPTH-1.
// CPU accesses go through a small FSM (IDLE -> [PTR] -> ACCESS -> IDLE).
// A loader port writes the array directly while the FSM is idle.
//
// Handshake: req is a one-cycle strobe. It is accepted only when the FSM is
// IDLE (busy=0) and load_en is low. An accepted access completes with a
// single-cycle ready pulse: 2 cycles after the req edge in direct mode,
// 3 cycles in indirect mode. The ready cycle is IDLE, so a new req may be
// raised in that same cycle. req or load_en while busy is ignored and
// sets the sticky err flag. load_en together with req in IDLE performs the
// load, drops the req and sets err.
//
// Ports:
//   clk, rst_mem_n          clock, synchronous active-low reset
//   req, addr, wr,
//   addr_mode, wr_data      CPU request (addr_mode 1 = pointer in memory)
//   rd_data, ready, busy    CPU response / status
//   load_en, load_addr,
//   load_data               loader write port (IDLE only)
//   err                     sticky error flag, cleared only by reset
//   dbg_state               current FSM state, for checkers
//
// Optional build macro: CPU_MEM_WRITE_PROTECT_EN
//   When defined, CPU writes whose effective address is below PROG_END are
//   dropped and set err (ready still pulses). The loader is never blocked.
// -----------------------------------------------------------------------------
module cpu_mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 1024,
  parameter int PROG_END = 401
) (
  input  logic              clk,
  input  logic              rst_mem_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic              addr_mode,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PTR    = 2'd1,
    ACCESS = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q,     state_d;
  logic              phase_q,     phase_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic              wr_q,        wr_d;
  logic [DATA_W-1:0] wr_data_q,   wr_data_d;
  logic [ADDR_W-1:0] eff_addr_q,  eff_addr_d;
  logic [DATA_W-1:0] rd_buf_q,    rd_buf_d;
  logic [DATA_W-1:0] rd_data_q,   rd_data_d;
  logic              ready_q,     ready_d;
  logic              err_q,       err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_blocked;

`ifdef CPU_MEM_WRITE_PROTECT_EN
  localparam logic [ADDR_W-1:0] PROG_END_A = ADDR_W'(PROG_END);
  assign wr_blocked = (eff_addr_q < PROG_END_A);
`else
  assign wr_blocked = 1'b0;
`endif

  // ACCESS runs for two edges: phase 0 registers the array word, phase 1
  // commits (rd_data update or array write) and raises ready. This keeps
  // the array read registered and gives the 2/3-cycle completion latency.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wr_data_d  = wr_data_q;
    eff_addr_d = eff_addr_q;
    rd_buf_d   = rd_buf_q;
    rd_data_d  = rd_data_q;
    ready_d    = 1'b0;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_waddr  = eff_addr_q;
    mem_wdata  = wr_data_q;

    unique case (state_q)
      IDLE: begin
        if (load_en) begin
          mem_we    = 1'b1;
          mem_waddr = load_addr;
          mem_wdata = load_data;
          if (req) err_d = 1'b1;
        end else if (req) begin
          addr_d    = addr;
          wr_d      = wr;
          wr_data_d = wr_data;
          phase_d   = 1'b0;
          if (addr_mode) begin
            state_d = PTR;
          end else begin
            eff_addr_d = addr;
            state_d    = ACCESS;
          end
        end
      end
      PTR: begin
        // Only the low ADDR_W bits of the pointer word are an address.
        eff_addr_d = mem[addr_q][ADDR_W-1:0];
        phase_d    = 1'b0;
        state_d    = ACCESS;
      end
      ACCESS: begin
        if (!phase_q) begin
          rd_buf_d = mem[eff_addr_q];
          phase_d  = 1'b1;
        end else begin
          if (wr_q) begin
            if (wr_blocked) err_d  = 1'b1;
            else            mem_we = 1'b1;
          end else begin
            rd_data_d = rd_buf_q;
          end
          ready_d = 1'b1;
          phase_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = 1'b0;
      end
    endcase

    if ((state_q != IDLE) && (req || load_en)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_mem_n) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wr_data_q  <= '0;
      eff_addr_q <= '0;
      rd_buf_q   <= '0;
      rd_data_q  <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wr_data_q  <= wr_data_d;
      eff_addr_q <= eff_addr_d;
      rd_buf_q   <= rd_buf_d;
      rd_data_q  <= rd_data_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  // Array is never reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (rst_mem_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_data   = rd_data_q;
  assign ready     = ready_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;
  localparam int AW       = 10;
  localparam int DW       = 16;
  localparam int PROG_END = 401;
`ifdef CPU_MEM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic          clk;
  logic          rst_mem_n;
  logic          req;
  logic [AW-1:0] addr;
  logic          wr;
  logic          addr_mode;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          ready;
  logic          busy;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          err;
  logic [1:0]    dbg_state;

  cpu_mem_responder dut (
    .clk       (clk),
    .rst_mem_n (rst_mem_n),
    .req       (req),
    .addr      (addr),
    .wr        (wr),
    .addr_mode (addr_mode),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .ready     (ready),
    .busy      (busy),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / cycle count
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // reference model and scoreboard
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] model_rd  = '0;
  bit            model_err = 1'b0;
  logic [DW-1:0] exp_q[$];
  int            lat_q[$];
  int            issue_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor: every ready pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got ready=1 with no request outstanding (cycle %0d)", cyc);
      end else begin
        logic [DW-1:0] e;
        int ic, l;
        e  = exp_q.pop_front();
        ic = issue_q.pop_front();
        l  = lat_q.pop_front();
        check("rd_data", rd_data, e);
        check("latency", cyc - ic, l);
      end
    end
  end

  // driver tasks (entered and left on a negedge)
  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic issue_op(input bit w, input bit m, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    logic [AW-1:0] ea;
    ea = m ? ref_mem[a][AW-1:0] : a;
    if (w) begin
      if (PROT && (int'(ea) < PROG_END)) model_err = 1'b1;
      else ref_mem[ea] = d;
    end else begin
      model_rd = ref_mem[ea];
    end
    exp_q.push_back(model_rd);
    lat_q.push_back(m ? 3 : 2);
    issue_q.push_back(cyc + 1);
    req       = 1'b1;
    wr        = w;
    addr_mode = m;
    addr      = a;
    wr_data   = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_ready(input int busy_exp);
    int n;
    int bc;
    n  = 0;
    bc = 0;
    while (ready !== 1'b1 && n < 10) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got no ready within 10 cycles expected one (cycle %0d)", cyc);
    end
    check("busy_cycles", bc, busy_exp);
  endtask

  task automatic do_op(input bit w, input bit m, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    issue_op(w, m, a, d);
    wait_ready(m ? 3 : 2);
  endtask

  initial begin
    rst_mem_n = 1'b0;
    req = 1'b0; wr = 1'b0; addr_mode = 1'b0; addr = '0; wr_data = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(negedge clk);
    check("reset_rd_data", rd_data, 0);
    check("reset_ready", ready, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    rst_mem_n = 1'b1;
    @(negedge clk);

    // preload the whole array so the model is exact everywhere
    for (int i = 0; i < 1024; i++) load_word(AW'(i), DW'($urandom));

    // directed: direct read, indirect read, direct + indirect writes
    load_word(10'd401, 16'h1234);
    do_op(1'b0, 1'b0, 10'd401, '0);
    check("direct_read_value", rd_data, 16'h1234);
    load_word(10'd402, 16'h0195);
    load_word(10'd405, 16'hBEEF);
    do_op(1'b0, 1'b1, 10'd402, '0);
    check("indirect_read_value", rd_data, 16'hBEEF);
    do_op(1'b1, 1'b0, 10'd410, 16'hA5A5);
    check("write_keeps_rd_data", rd_data, 16'hBEEF);
    load_word(10'd411, 16'h019C);
    do_op(1'b1, 1'b1, 10'd411, 16'h5A5A);
    do_op(1'b0, 1'b0, 10'd410, '0);
    check("mem410", rd_data, 16'hA5A5);
    do_op(1'b0, 1'b0, 10'd412, '0);
    check("mem412", rd_data, 16'h5A5A);
    // indirect self-reference
    load_word(10'd440, 16'h01B8);
    do_op(1'b0, 1'b1, 10'd440, '0);
    check("self_ref", rd_data, 16'h01B8);
    // top-of-array address
    do_op(1'b1, 1'b0, 10'd1023, 16'hC0DE);
    do_op(1'b0, 1'b0, 10'd1023, '0);

    // randomized back-to-back traffic with occasional loads
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        load_word(AW'($urandom_range(0, 1023)), DW'($urandom));
      end
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 1023)), DW'($urandom));
    end
    check("err_after_random", err, 32'(model_err));

    // collision: req while busy is ignored and flags err
    load_word(10'd401, 16'h1234);
    issue_op(1'b0, 1'b0, 10'd401, '0);
    check("busy_first_cycle", busy, 1);
    req = 1'b1; wr = 1'b1; addr_mode = 1'b0; addr = 10'd401; wr_data = 16'hDEAD;
    model_err = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_ready(1);
    do_op(1'b0, 1'b0, 10'd401, '0);
    check("busy_req_no_write", rd_data, 16'h1234);
    check("err_busy_req", err, 1);

    // collision: load_en with req in IDLE, load wins
    load_en = 1'b1; load_addr = 10'd420; load_data = 16'h7777;
    ref_mem[420] = 16'h7777;
    req = 1'b1; wr = 1'b1; addr_mode = 1'b0; addr = 10'd421; wr_data = 16'h9999;
    @(negedge clk);
    load_en = 1'b0; req = 1'b0;
    check("load_req_not_busy", busy, 0);
    repeat (4) @(negedge clk);
    do_op(1'b0, 1'b0, 10'd420, '0);
    check("load_won", rd_data, 16'h7777);
    do_op(1'b0, 1'b0, 10'd421, '0);
    check("dropped_req_no_write", rd_data, ref_mem[421]);
    check("err_load_req", err, 1);

    // reset in PTR of an indirect write aborts it
    load_word(10'd430, 16'h1357);
    load_word(10'd431, 16'h01AE);
    req = 1'b1; wr = 1'b1; addr_mode = 1'b1; addr = 10'd431; wr_data = 16'hDEAD;
    @(negedge clk);
    req = 1'b0;
    check("ptr_busy", busy, 1);
    rst_mem_n = 1'b0;
    @(negedge clk);
    rst_mem_n = 1'b1;
    model_rd  = '0;
    model_err = 1'b0;
    check("midrst_ready", ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    check("midrst_rd_data", rd_data, 0);
    repeat (4) @(negedge clk);
    do_op(1'b0, 1'b0, 10'd430, '0);
    check("midrst_target", rd_data, 16'h1357);

    // program-region write (suppressed only with write protection)
    load_word(10'd10, 16'h1111);
    do_op(1'b1, 1'b0, 10'd10, 16'hFFFF);
    do_op(1'b0, 1'b0, 10'd10, '0);
    check("prog_write_value", rd_data, PROT ? 16'h1111 : 16'hFFFF);
    check("prog_write_err", err, PROT ? 1 : 0);

    repeat (5) @(negedge clk);
    check("outstanding_requests", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
